// File: rtl/mem_interconnect_if.sv
// ============================================================================
// mem_interconnect_if : picorv32-style request bus plus fan-out slave signals
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_interconnect_if #(
  parameter int NUM_SLAVES = 5
);
  logic                      mem_valid;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_wstrb;
  logic                      mem_ready;
  logic [31:0]               mem_rdata;
  logic [NUM_SLAVES-1:0]     slave_sel;
  logic [NUM_SLAVES-1:0]     slave_ready;
  logic [32*NUM_SLAVES-1:0]  slave_rdata;
  logic [31:0]               slave_addr;
  logic [31:0]               slave_wdata;
  logic [3:0]                slave_wstrb;

  // master: the environment (CPU and slave devices); slave: the interconnect
  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, slave_ready, slave_rdata,
    input  mem_ready, mem_rdata, slave_sel, slave_addr, slave_wdata, slave_wstrb
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, slave_ready, slave_rdata,
    output mem_ready, mem_rdata, slave_sel, slave_addr, slave_wdata, slave_wstrb
  );
endinterface

`default_nettype wire

// File: rtl/mem_interconnect.sv
// ============================================================================
// mem_interconnect : address-decoding 1-to-N bus router with unmapped/timeout errors
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_interconnect #(
  parameter int                      NUM_SLAVES     = 5,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE    = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK    = '0,
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_interconnect_if.slave  bus,
  output logic               err_unmapped,
  output logic               err_timeout,
  output logic [7:0]         err_count
);

  localparam int          IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_ACCESS    = 2'd1;
  localparam logic [1:0]  S_ERR       = 2'd2;
  // The request cycle itself is the first stalled cycle, so ACCESS only has to count the rest.
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           stall_q, stall_d;
  logic                  err_to_q, err_to_d;
  logic [7:0]            err_count_q, err_count_d;

  logic [NUM_SLAVES-1:0] hit;
  logic                  any_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  route_en;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic [15:0]           stall_inc;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi] = (bus.mem_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
    end
  endgenerate

  assign any_hit = |hit;

  always_comb begin
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) dec_idx = IDX_W'(i);
    end
  end

  // Reset gates routing so select/ready drop the instant reset asserts.
  assign sel_idx  = (state_q == S_ACCESS) ? idx_q : dec_idx;
  assign route_en = !reset && bus.mem_valid &&
                    (((state_q == S_IDLE) && any_hit) || (state_q == S_ACCESS));

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = bus.slave_ready[i];
        sel_rdata = bus.slave_rdata[32*i +: 32];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign bus.slave_sel[gi] = route_en && (sel_idx == IDX_W'(gi));
    end
  endgenerate

  assign bus.mem_ready   = (state_q == S_ERR) || (route_en && sel_ready);
  assign bus.mem_rdata   = (state_q == S_ERR)        ? ERR_RDATA :
                           (route_en && sel_ready)   ? sel_rdata : 32'h0;
  assign bus.slave_addr  = bus.mem_addr;
  assign bus.slave_wdata = bus.mem_wdata;
  assign bus.slave_wstrb = bus.mem_wstrb;

  assign err_unmapped = (state_q == S_ERR) && !err_to_q;
  assign err_timeout  = (state_q == S_ERR) && err_to_q;
  assign err_count    = err_count_q;

  assign stall_inc = stall_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stall_d     = stall_q;
    err_to_d    = err_to_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (bus.mem_valid) begin
          if (!any_hit) begin
            state_d  = S_ERR;
            err_to_d = 1'b0;
          end else if (!sel_ready) begin
            state_d = S_ACCESS;
            idx_d   = dec_idx;
          end
        end
      end
      S_ACCESS: begin
        if (!bus.mem_valid || sel_ready) begin
          state_d = S_IDLE;
        end else begin
          stall_d = stall_inc;
          if (stall_inc >= STALL_LIMIT) begin
            state_d  = S_ERR;
            err_to_d = 1'b1;
          end
        end
      end
      S_ERR: begin
        state_d     = S_IDLE;
        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stall_q     <= '0;
      err_to_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stall_q     <= stall_d;
      err_to_q    <= err_to_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

`default_nettype wire
